fir_filter: RTL and testbench

- 15-tap, fixed-coefficient, direct-form FIR low-pass filter with AXI4-Stream slave input and AXI4-Stream master output.
- Takes 16-bit signed samples and produces 32-bit signed full-precision results.
- Sits between a sample source (ADC or waveform generator) and a downstream stream consumer.
- Backpressure from the consumer stalls the whole pipeline.

---
 rtl/fir_filter_if.sv | 31 +++
 rtl/fir_filter.sv | 93 +++++++++
 tb/tb_fir_filter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_filter_if.sv
// AXI4-Stream bundle for the 15-tap FIR filter.
// Carries both the sample input stream (s_axis_fir_*) and the result output
// stream (m_axis_fir_*).
//   slave  modport : the filter's view (consumes s_axis_fir_*, produces m_axis_fir_*)
//   master modport : the environment's view (sample source + result consumer)
interface fir_filter_if;
    logic [15:0] s_axis_fir_tdata;
    logic [3:0]  s_axis_fir_tkeep;
    logic        s_axis_fir_tlast;
    logic        s_axis_fir_tvalid;
    logic        s_axis_fir_tready;
    logic        m_axis_fir_tready;
    logic        m_axis_fir_tvalid;
    logic        m_axis_fir_tlast;
    logic [3:0]  m_axis_fir_tkeep;
    logic [31:0] m_axis_fir_tdata;

    modport slave (
        input  s_axis_fir_tdata, s_axis_fir_tkeep, s_axis_fir_tlast, s_axis_fir_tvalid,
        output s_axis_fir_tready,
        input  m_axis_fir_tready,
        output m_axis_fir_tvalid, m_axis_fir_tlast, m_axis_fir_tkeep, m_axis_fir_tdata
    );

    modport master (
        output s_axis_fir_tdata, s_axis_fir_tkeep, s_axis_fir_tlast, s_axis_fir_tvalid,
        input  s_axis_fir_tready,
        output m_axis_fir_tready,
        input  m_axis_fir_tvalid, m_axis_fir_tlast, m_axis_fir_tkeep, m_axis_fir_tdata
    );
endinterface

// File: rtl/fir_filter.sv
// 15-tap fixed-coefficient direct-form FIR low-pass filter.
// 16-bit signed samples in, 32-bit signed full-precision results out.
// Two pipeline stages: stage 1 is the sample delay line, stage 2 registers
// the sum of products. Consumer backpressure (m_axis_fir_tready=0) freezes
// every register, so the whole pipeline stalls as one.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   axis  : fir_filter_if.slave (s_axis_fir_* in, m_axis_fir_* out)
module fir_filter (
    input  logic        clk,
    input  logic        reset,
    fir_filter_if.slave axis
);
    localparam int unsigned NTAPS = 15;
    // C0 in bits [15:0]; the set is symmetric so listing order is immaterial.
    localparam logic [NTAPS*16-1:0] COEFFS = {
        16'hFC9C, 16'h0000, 16'h06D3, 16'h0000, 16'hF396,
        16'h0000, 16'h27F5, 16'h4000, 16'h27F5, 16'h0000,
        16'hF396, 16'h0000, 16'h06D3, 16'h0000, 16'hFC9C
    };

    logic               en;
    logic               accept;
    logic signed [15:0] d_q [NTAPS];
    logic signed [15:0] d_d [NTAPS];
    logic               v1_q, v1_d;
    logic               l1_q, l1_d;
    logic signed [31:0] acc;
    logic [31:0]        tdata_q;
    logic               tvalid_q;
    logic               tlast_q;
    logic               unused_tkeep;

    assign en     = axis.m_axis_fir_tready;
    assign accept = axis.s_axis_fir_tvalid & axis.s_axis_fir_tready;

    assign axis.s_axis_fir_tready = axis.m_axis_fir_tready & reset;
    assign axis.m_axis_fir_tkeep  = 4'hF;
    assign axis.m_axis_fir_tdata  = tdata_q;
    assign axis.m_axis_fir_tvalid = tvalid_q;
    assign axis.m_axis_fir_tlast  = tlast_q;

    // Input keep is not interpreted; all 16 sample bits are always used.
    assign unused_tkeep = ^axis.s_axis_fir_tkeep;

    // Stage 1: delay line shifts only on an accepted sample.
    always_comb begin
        for (int unsigned k = 0; k < NTAPS; k++) begin
            d_d[k] = d_q[k];
        end
        v1_d = 1'b0;
        l1_d = 1'b0;
        if (accept) begin
            d_d[0] = signed'(axis.s_axis_fir_tdata);
            for (int unsigned k = 1; k < NTAPS; k++) begin
                d_d[k] = d_q[k-1];
            end
            v1_d = 1'b1;
            l1_d = axis.s_axis_fir_tlast;
        end
    end

    // Stage 2: sum of 16x16 products in 32-bit two's complement (wraps).
    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            acc = acc + (32'(signed'(COEFFS[16*k +: 16])) * 32'(d_q[k]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                d_q[k] <= '0;
            end
            v1_q     <= 1'b0;
            l1_q     <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (en) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                d_q[k] <= d_d[k];
            end
            v1_q     <= v1_d;
            l1_q     <= l1_d;
            tdata_q  <= acc;
            tvalid_q <= v1_q;
            tlast_q  <= l1_q;
        end
    end
endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: directed impulse/step/stall/gap/sine
// phases plus randomized traffic, all checked against a convolution model.
module tb_fir_filter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fir_filter_if axis ();

    fir_filter dut (
        .clk   (clk),
        .reset (reset),
        .axis  (axis.slave)
    );

    int checks = 0;
    int errors = 0;

    int coef [15] = '{-868, 0, 1747, 0, -3178, 0, 10229, 16384, 10229, 0, -3178, 0, 1747, 0, -868};

    // Reference state: accepted-sample history (newest first), the result
    // owed for the most recent accept, and the expected visible output.
    int          hist [$];
    logic        pend_v, pend_l;
    logic [31:0] pend_d;
    logic        exp_v, exp_l;
    logic [31:0] exp_d;

    // Output beats observed on enabled cycles.
    logic [31:0] beats [$];
    logic        lasts [$];

    logic [15:0] sine [8] = '{16'h0000, 16'h5A7E, 16'h7FFF, 16'h5A7E, 16'h0000, 16'hA582, 16'h8000, 16'hA582};

    function automatic logic [31:0] conv();
        longint s = 0;
        for (int k = 0; k < 15 && k < hist.size(); k++) begin
            s += longint'(coef[k]) * longint'(hist[k]);
        end
        return s[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        pend_v = 1'b0; pend_l = 1'b0; pend_d = '0;
        exp_v  = 1'b0; exp_l  = 1'b0; exp_d  = '0;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic mr);
        axis.s_axis_fir_tvalid = v;
        axis.s_axis_fir_tdata  = d;
        axis.s_axis_fir_tlast  = l;
        axis.s_axis_fir_tkeep  = 4'($urandom);
        axis.m_axis_fir_tready = mr;
    endtask

    // One clock: model the edge from pre-edge inputs, then check outputs #1 later.
    task automatic cycle();
        logic        en, acc;
        logic [15:0] din;
        logic        lin;
        en  = axis.m_axis_fir_tready && reset;
        acc = en && axis.s_axis_fir_tvalid;
        din = axis.s_axis_fir_tdata;
        lin = axis.s_axis_fir_tlast;
        @(posedge clk);
        #1;
        if (en) begin
            exp_v = pend_v; exp_l = pend_l;
            if (pend_v) exp_d = pend_d;
            if (acc) begin
                hist.push_front(int'($signed(din)));
                if (hist.size() > 15) void'(hist.pop_back());
                pend_v = 1'b1; pend_d = conv(); pend_l = lin;
            end else begin
                pend_v = 1'b0; pend_l = 1'b0;
            end
            if (axis.m_axis_fir_tvalid === 1'b1) begin
                beats.push_back(axis.m_axis_fir_tdata);
                lasts.push_back(axis.m_axis_fir_tlast);
            end
        end
        chk("tvalid", 32'(axis.m_axis_fir_tvalid), 32'(exp_v));
        chk("tlast", 32'(axis.m_axis_fir_tlast), 32'(exp_l));
        if (exp_v) chk("tdata", axis.m_axis_fir_tdata, exp_d);
        chk("tkeep", 32'(axis.m_axis_fir_tkeep), 32'hF);
        chk("s_tready", 32'(axis.s_axis_fir_tready), 32'(axis.m_axis_fir_tready & reset));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 32'(axis.m_axis_fir_tvalid), 32'h0);
        chk({tag, "_tdata"}, axis.m_axis_fir_tdata, 32'h0);
        chk({tag, "_tlast"}, 32'(axis.m_axis_fir_tlast), 32'h0);
        chk({tag, "_tkeep"}, 32'(axis.m_axis_fir_tkeep), 32'hF);
        chk({tag, "_s_tready"}, 32'(axis.s_axis_fir_tready), 32'h0);
    endtask

    initial begin
        int          invalid_cnt;
        int          ones;
        logic [31:0] snap_d;
        logic        snap_v, snap_l;

        model_clear();
        drive(1'b1, 16'h1234, 1'b0, 1'b1);

        // Reset held for two clocks with a valid source.
        #1;
        check_reset_outputs("rst_t0");
        cycle();
        cycle();
        check_reset_outputs("rst_hold");
        reset = 1'b1;

        // Impulse: 16'h4000 then zeros; first result one clock after accept.
        beats.delete(); lasts.delete();
        drive(1'b1, 16'h4000, 1'b0, 1'b1);
        cycle();
        chk("imp_latency_accept_edge", 32'(axis.m_axis_fir_tvalid), 32'h0);
        drive(1'b1, 16'h0000, 1'b0, 1'b1);
        cycle();
        chk("imp_latency_next_edge", 32'(axis.m_axis_fir_tvalid), 32'h1);
        for (int i = 0; i < 18; i++) cycle();
        if (beats.size() >= 16) begin
            chk("imp_c0", beats[0], 32'hFF270000);
            chk("imp_c1", beats[1], 32'h00000000);
            chk("imp_c2", beats[2], 32'h01B4C000);
            chk("imp_c7", beats[7], 32'h10000000);
            chk("imp_c14", beats[14], 32'hFF270000);
            chk("imp_tail", beats[15], 32'h00000000);
        end else begin
            chk("imp_beat_count", 32'(beats.size()), 32'd16);
        end

        // DC step to full scale.
        beats.delete(); lasts.delete();
        drive(1'b1, 16'h7FFF, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle();
        chk("dc_settled", axis.m_axis_fir_tdata, 32'd1056539148);
        chk("dc_stable_a", beats[beats.size()-2], 32'd1056539148);
        chk("dc_stable_b", beats[beats.size()-4], 32'd1056539148);

        // Backpressure mid-stream: 10 stalled clocks, outputs frozen.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            cycle();
        end
        snap_d = axis.m_axis_fir_tdata;
        snap_v = axis.m_axis_fir_tvalid;
        snap_l = axis.m_axis_fir_tlast;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'($urandom), 1'b1, 1'b0);
            cycle();
            chk("stall_tdata", axis.m_axis_fir_tdata, snap_d);
            chk("stall_tvalid", 32'(axis.m_axis_fir_tvalid), 32'(snap_v));
            chk("stall_tlast", 32'(axis.m_axis_fir_tlast), 32'(snap_l));
            chk("stall_s_tready", 32'(axis.s_axis_fir_tready), 32'h0);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'($urandom), 1'b0, 1'b1);
            cycle();
        end

        // Source gap of 5 clocks: exactly 5 invalid output beats, shifted by one.
        invalid_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            drive(i >= 5, 16'($urandom), 1'b0, 1'b1);
            cycle();
            if (axis.m_axis_fir_tvalid !== 1'b1) invalid_cnt++;
        end
        chk("gap_invalid_beats", 32'(invalid_cnt), 32'd5);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'($urandom), 1'b0, 1'b1);
            cycle();
        end

        // Sine, each point held 5 samples, tlast on the 8th sample.
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle();
        beats.delete(); lasts.delete();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, sine[i/5], i == 7, 1'b1);
            cycle();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle();
        cycle();
        ones = 0;
        foreach (lasts[i]) if (lasts[i]) ones++;
        chk("sine_beats", 32'(beats.size()), 32'd40);
        chk("tlast_count", 32'(ones), 32'd1);
        if (lasts.size() > 7) chk("tlast_on_8th", 32'(lasts[7]), 32'h1);

        // Randomized traffic with random gaps and backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] d;
            d = (i % 37 == 0) ? 16'h8000 : 16'($urandom);
            drive($urandom_range(0, 3) != 0, d, 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0);
            cycle();
        end

        // Asynchronous reset mid-stream: outputs clear without an edge.
        drive(1'b1, 16'h7FFF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b0;
        #1;
        model_clear();
        check_reset_outputs("async_rst");
        cycle();
        reset = 1'b1;
        // History cleared: first result uses zeros for missing taps.
        drive(1'b1, 16'h0100, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 16'h0000, 1'b0, 1'b1);
        cycle();
        chk("post_rst_first", axis.m_axis_fir_tdata, 32'(-868 * 256));
        for (int i = 0; i < 20; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, required completion");
        $fatal(1, "timeout");
    end
endmodule
